// File: rtl/txreq_rd_throttle_if.sv
// txreq_rd_throttle_if: AXI-S TXREQ channel bundle.
// Ports: tvalid/tready handshake with tdata, tkeep, tlast and tuser_vendor payload.
// Modports: master drives the beat, slave returns tready.
interface txreq_rd_throttle_if #(
  parameter int DATA_W = 256,
  parameter int USER_W = 10
);
  logic                tvalid;
  logic                tready;
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic                tlast;
  logic [USER_W-1:0]   tuser_vendor;
  modport master (output tvalid, tdata, tkeep, tlast, tuser_vendor, input tready);
  modport slave (input tvalid, tdata, tkeep, tlast, tuser_vendor, output tready);
endinterface

// File: rtl/txreq_rd_throttle.sv
// txreq_rd_throttle: outstanding-read limiter on the host TXREQ path with a 2-entry output FIFO.
// Ports: clk, rst_n (async active-low); txreq_in (slave) / txreq_out (master) TXREQ streams;
// cpl_done retires one read; limit_en enables the MAX_OUTSTANDING gate; outstanding is the
// in-flight count; stall_cycles counts limit-induced stalls; err_underflow is a sticky underflow flag.
module txreq_rd_throttle #(
  parameter int DATA_W          = 256,
  parameter int USER_W          = 10,
  parameter int MAX_OUTSTANDING = 64,
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  txreq_rd_throttle_if.slave         txreq_in,
  txreq_rd_throttle_if.master        txreq_out,
  input  logic                       cpl_done,
  input  logic                       limit_en,
  output logic [CNT_W-1:0]           outstanding,
  output logic [31:0]                stall_cycles,
  output logic                       err_underflow
);
  localparam int W = DATA_W + DATA_W / 8 + 1 + USER_W;
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTSTANDING);
  logic [W-1:0]     mem_q [2];
  logic             wp_q, rp_q;
  logic [1:0]       fcnt_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      stall_q;
  logic             err_q;
  logic             not_full, at_limit, push, pop, inc, dec;
  assign not_full = fcnt_q != 2'd2;
  // Gate on the registered count only, so a completion frees a slot one cycle later.
  assign at_limit = limit_en && cnt_q >= MAX_C;
  // rst_n term holds tready low for the whole time reset is asserted.
  assign txreq_in.tready = rst_n && not_full && !at_limit;
  assign push = txreq_in.tvalid && txreq_in.tready;
  assign pop  = txreq_out.tvalid && txreq_out.tready;
  assign inc  = push && txreq_in.tlast;
  assign dec  = cpl_done;
  // Inc and dec together cancel; both ends saturate instead of wrapping.
  always_comb
    cnt_d = (inc && !dec && cnt_q != '1) ? cnt_q + CNT_W'(1) :
            (dec && !inc && cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp_q    <= 1'b0;
      rp_q    <= 1'b0;
      fcnt_q  <= 2'd0;
      cnt_q   <= '0;
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (push) wp_q <= !wp_q;
      if (pop) rp_q <= !rp_q;
      fcnt_q <= fcnt_q + {1'b0, push} - {1'b0, pop};
      cnt_q  <= cnt_d;
      if (txreq_in.tvalid && not_full && at_limit && stall_q != '1) stall_q <= stall_q + 32'd1;
      if (dec && !inc && cnt_q == '0) err_q <= 1'b1;
    end
  always_ff @(posedge clk)
    if (push) mem_q[wp_q] <= {txreq_in.tdata, txreq_in.tkeep, txreq_in.tlast, txreq_in.tuser_vendor};
  assign txreq_out.tvalid = fcnt_q != 2'd0;
  assign {txreq_out.tdata, txreq_out.tkeep, txreq_out.tlast, txreq_out.tuser_vendor} = mem_q[rp_q];
  assign outstanding   = cnt_q;
  assign stall_cycles  = stall_q;
  assign err_underflow = err_q;
endmodule

// File: tb/tb_txreq_rd_throttle.sv
// tb_txreq_rd_throttle: scoreboard bench for txreq_rd_throttle with MAX_OUTSTANDING=4.
module tb_txreq_rd_throttle;
  localparam int DW  = 256;
  localparam int UW  = 10;
  localparam int MAX = 4;
  localparam int CW  = $clog2(MAX + 1);
  localparam int BW  = DW + DW / 8 + 1 + UW;
  typedef logic [BW-1:0] beat_t;
  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cpl_done = 1'b0;
  logic          limit_en = 1'b1;
  logic [CW-1:0] outstanding;
  logic [31:0]   stall_cycles;
  logic          err_underflow;
  int            checks = 0;
  int            failures = 0;
  int            emitted = 0;
  int            e0;
  beat_t         exp_q[$];
  beat_t         mon_got, mon_exp;
  txreq_rd_throttle_if #(.DATA_W(DW), .USER_W(UW)) in_if ();
  txreq_rd_throttle_if #(.DATA_W(DW), .USER_W(UW)) out_if ();
  txreq_rd_throttle #(.DATA_W(DW), .USER_W(UW), .MAX_OUTSTANDING(MAX)) dut (
    .clk(clk), .rst_n(rst_n), .txreq_in(in_if), .txreq_out(out_if),
    .cpl_done(cpl_done), .limit_en(limit_en), .outstanding(outstanding),
    .stall_cycles(stall_cycles), .err_underflow(err_underflow)
  );
  always #5 clk = ~clk;
  function automatic beat_t mk(int v, logic last);
    logic [31:0] w = v;
    return {{8{w}}, {4{w[7:0]}}, last, w[9:0] ^ 10'h155};
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pulse();
    cpl_done = 1'b1;
    tick(1);
    cpl_done = 1'b0;
  endtask
  task automatic drive(int v, logic last);
    {in_if.tdata, in_if.tkeep, in_if.tlast, in_if.tuser_vendor} = mk(v, last);
    in_if.tvalid = 1'b1;
  endtask
  task automatic send(int v, logic last);
    bit ok = 1'b0;
    drive(v, last);
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (in_if.tready) begin
        exp_q.push_back(mk(v, last));
        ok = 1'b1;
      end
    end
    tick(1);
    in_if.tvalid = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL send_timeout: beat %0h accepted=0 required=1 within 100 cycles", v);
    end
  endtask
  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_in_tready", in_if.tready, 0);
    chk("rst_out_tvalid", out_if.tvalid, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_stall", stall_cycles, 0);
    chk("rst_err", err_underflow, 0);
    exp_q.delete();
    tick(2);
    rst_n = 1'b1;
  endtask
  // Output monitor: a handshake seen at the negedge completes on the following posedge.
  always @(negedge clk)
    if (rst_n && out_if.tvalid && out_if.tready) begin
      mon_got = {out_if.tdata, out_if.tkeep, out_if.tlast, out_if.tuser_vendor};
      emitted++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_beat: got %0h expected none", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          failures++;
          $display("FAIL beat_payload: got %0h expected %0h", mon_got, mon_exp);
        end
      end
    end
  initial begin
    in_if.tvalid = 1'b0;
    {in_if.tdata, in_if.tkeep, in_if.tlast, in_if.tuser_vendor} = '0;
    out_if.tready = 1'b1;
    do_reset();
    @(negedge clk);
    chk("post_rst_tready", in_if.tready, 1);
    tick(1);
    // underflow is sticky until reset
    pulse();
    chk("uf_cnt", outstanding, 0);
    chk("uf_err", err_underflow, 1);
    tick(5);
    chk("uf_sticky", err_underflow, 1);
    do_reset();
    // basic flow: four reads fill the limit, fifth stalls
    for (int v = 1; v <= 4; v++) send(v, 1'b1);
    chk("limit_cnt", outstanding, 4);
    drive(5, 1'b1);
    @(negedge clk);
    chk("limit_tready", in_if.tready, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("stall_3", stall_cycles, 3);
    cpl_done = 1'b1;
    @(negedge clk);
    chk("cpl_same_cycle_tready", in_if.tready, 0);
    tick(1);
    cpl_done = 1'b0;
    chk("stall_4", stall_cycles, 4);
    chk("cpl_dec", outstanding, 3);
    @(negedge clk);
    chk("cpl_next_tready", in_if.tready, 1);
    exp_q.push_back(mk(5, 1'b1));
    tick(1);
    in_if.tvalid = 1'b0;
    chk("refill_cnt", outstanding, 4);
    // simultaneous inc/dec and uncounted tlast=0 beat
    pulse();
    chk("dec_to_3", outstanding, 3);
    cpl_done = 1'b1;
    send(6, 1'b1);
    cpl_done = 1'b0;
    chk("simul_3", outstanding, 3);
    send(7, 1'b0);
    chk("tlast0_uncounted", outstanding, 3);
    repeat (3) pulse();
    chk("drain_0", outstanding, 0);
    cpl_done = 1'b1;
    send(8, 1'b1);
    cpl_done = 1'b0;
    chk("simul_0_cnt", outstanding, 0);
    chk("simul_0_err", err_underflow, 0);
    // count-only mode saturates at 2^CNT_W-1
    limit_en = 1'b0;
    for (int v = 10; v <= 18; v++) send(v, 1'b1);
    chk("sat_cnt", outstanding, 7);
    chk("sat_stall", stall_cycles, 4);
    limit_en = 1'b1;
    drive(19, 1'b1);
    @(negedge clk);
    chk("relimit_tready", in_if.tready, 0);
    #1 limit_en = 1'b0;
    #1;
    chk("unlimit_tready", in_if.tready, 1);
    in_if.tvalid = 1'b0;
    limit_en = 1'b1;
    do_reset();
    // output backpressure: FIFO holds two beats, payload stable while stalled
    out_if.tready = 1'b0;
    fork
      begin
        send(32'hA, 1'b1);
        send(32'hB, 1'b1);
        send(32'hC, 1'b1);
      end
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("bp_tready", in_if.tready, 0);
        chk("bp_cnt", outstanding, 2);
        chk("bp_stall", stall_cycles, 0);
        chk("bp_tvalid", out_if.tvalid, 1);
        chk("bp_head", out_if.tdata[31:0], 32'hA);
        repeat (2) @(negedge clk);
        chk("bp_head_stable", out_if.tdata[31:0], 32'hA);
        tick(1);
        out_if.tready = 1'b1;
      end
    join
    tick(5);
    chk("bp_drained", exp_q.size(), 0);
    chk("bp_cnt3", outstanding, 3);
    // async reset with two beats buffered
    do_reset();
    out_if.tready = 1'b0;
    send(32'h20, 1'b1);
    send(32'h21, 1'b1);
    chk("pre_rst_cnt", outstanding, 2);
    chk("pre_rst_tvalid", out_if.tvalid, 1);
    e0 = emitted;
    do_reset();
    out_if.tready = 1'b1;
    tick(5);
    chk("no_beat_after_rst", emitted, e0);
    pulse();
    chk("post_rst_uf", err_underflow, 1);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
